control_sequencer: RTL and testbench

- Microsequencer directly upstream of the 8-bit datapath; generates every datapath control strobe.
- Fetches instruction bytes from RAM through the datapath bus, latches them in an internal instruction register (IR) and steps a per-opcode micro-sequence.
- Handles branching from the datapath zero flag and halts on HLT.

---
 rtl/control_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: microsequencer that drives every control strobe of the
// 8-bit datapath. Fetches an instruction byte into IR, then steps its
// per-opcode micro-sequence. Strobes are a pure decode of state/step/IR.
// Optional build macro SEQ_SINGLE_STEP_EN adds i_stepReq: the sequencer then
// leaves FADDR only on a cycle with i_stepReq=1 (one instruction per pulse).
module control_sequencer #(
    parameter int DATA_W        = 8,
    parameter bit RESET_PC_ZERO = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic              i_stepReq,
`endif
    input  logic [DATA_W-1:0] i_bus,
    input  logic              i_flagZero,
    output logic              o_ctrlPcOE,
    output logic              o_ctrlPcInc,
    output logic              o_ctrlPcLoad,
    output logic              o_ctrlPcClear,
    output logic              o_ctrlRamAddressEn,
    output logic              o_ctrlRamOE,
    output logic              o_ctrlRamWriteEn,
    output logic              o_ctrlRegBusSel,
    output logic              o_ctrlRegBusEn,
    output logic              o_ctrlRegWr0,
    output logic              o_ctrlRegWr1,
    output logic              o_ctrlAluBWr,
    output logic [1:0]        o_ctrlAluOp,
    output logic              o_ctrlAluShiftLeft,
    output logic              o_ctrlAluOE,
    output logic              o_halted
);

    typedef enum logic [2:0] {
        S_RESET, S_FADDR, S_FDATA, S_EXEC, S_HALT
    } state_t;

    localparam logic [2:0] OP_NOP = 3'b000, OP_LDI = 3'b001, OP_ALU = 3'b010,
                           OP_SHF = 3'b011, OP_ST  = 3'b100, OP_LD  = 3'b101,
                           OP_JZ  = 3'b110, OP_HLT = 3'b111;

    state_t            state;
    logic [1:0]        step;
    logic [DATA_W-1:0] ir;
    logic              jz_take;   // zero flag captured on entry to step 0
    logic              go;        // permission to leave FADDR

`ifdef SEQ_SINGLE_STEP_EN
    assign go = i_stepReq;
`else
    assign go = 1'b1;
`endif

    logic [2:0] op;
    logic       rd, rs;
    assign op = ir[7:5];
    assign rd = ir[4];
    assign rs = ir[3];

    // Final step index of the current opcode
    logic last_step;
    always_comb begin
        last_step = 1'b0;
        case (op)
            OP_NOP:        last_step = (step == 2'd0);
            OP_LDI, OP_ST,
            OP_LD:         last_step = (step == 2'd1);
            OP_ALU:        last_step = (step == 2'd2);
            OP_SHF:        last_step = (step == 2'd3);
            OP_JZ:         last_step = jz_take ? (step == 2'd1) : (step == 2'd0);
            default:       last_step = 1'b1;
        endcase
    end

    // State, step counter and IR; the flag is latched with IR so that the
    // JZ step-0 strobes depend only on registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= S_RESET;
            step    <= 2'd0;
            ir      <= '0;
            jz_take <= 1'b0;
        end else begin
            case (state)
                S_RESET: state <= S_FADDR;
                S_FADDR: if (go) state <= S_FDATA;
                S_FDATA: begin
                    ir      <= i_bus;
                    jz_take <= i_flagZero;
                    step    <= 2'd0;
                    state   <= S_EXEC;
                end
                S_EXEC: begin
                    if (op == OP_HLT) begin
                        state <= S_HALT;
                    end else if (last_step) begin
                        state <= S_FADDR;
                        step  <= 2'd0;
                    end else begin
                        step  <= step + 2'd1;
                    end
                end
                default: state <= S_HALT;
            endcase
        end
    end

    // Strobe decode: only one of PcOE/RamOE/RegBusEn/AluOE per cycle
    always_comb begin
        o_ctrlPcOE = 1'b0;          o_ctrlPcInc = 1'b0;
        o_ctrlPcLoad = 1'b0;        o_ctrlPcClear = 1'b0;
        o_ctrlRamAddressEn = 1'b0;  o_ctrlRamOE = 1'b0;
        o_ctrlRamWriteEn = 1'b0;    o_ctrlRegBusSel = 1'b0;
        o_ctrlRegBusEn = 1'b0;      o_ctrlRegWr0 = 1'b0;
        o_ctrlRegWr1 = 1'b0;        o_ctrlAluBWr = 1'b0;
        o_ctrlAluOp = 2'b00;        o_ctrlAluShiftLeft = 1'b0;
        o_ctrlAluOE = 1'b0;         o_halted = 1'b0;
        case (state)
            S_RESET: o_ctrlPcClear = RESET_PC_ZERO;
            S_FADDR: begin
                o_ctrlPcOE         = go;
                o_ctrlRamAddressEn = go;
            end
            S_FDATA: begin
                o_ctrlRamOE = 1'b1;
                o_ctrlPcInc = 1'b1;
            end
            S_EXEC: begin
                case (op)
                    OP_LDI, OP_SHF: begin
                        // immediate fetch occupies steps 0 and 1
                        if (step == 2'd0) begin
                            o_ctrlPcOE = 1'b1;  o_ctrlRamAddressEn = 1'b1;
                        end else if (step == 2'd1) begin
                            o_ctrlRamOE = 1'b1; o_ctrlPcInc = 1'b1;
                            if (op == OP_LDI) {o_ctrlRegWr1, o_ctrlRegWr0} = rd ? 2'b10 : 2'b01;
                            else              o_ctrlAluBWr = 1'b1;
                        end else begin
                            // A operand is rd; op and direction held into write-back
                            o_ctrlAluOp        = 2'b11;
                            o_ctrlAluShiftLeft = ir[2];
                            o_ctrlRegBusSel    = rd;
                            if (step == 2'd3) begin
                                o_ctrlAluOE = 1'b1;
                                {o_ctrlRegWr1, o_ctrlRegWr0} = rd ? 2'b10 : 2'b01;
                            end
                        end
                    end
                    OP_ALU: begin
                        if (step == 2'd0) begin
                            o_ctrlRegBusSel = rs; o_ctrlRegBusEn = 1'b1; o_ctrlAluBWr = 1'b1;
                        end else begin
                            o_ctrlAluOp = ir[1:0];
                            if (step == 2'd2) begin
                                o_ctrlAluOE = 1'b1;
                                {o_ctrlRegWr1, o_ctrlRegWr0} = rd ? 2'b10 : 2'b01;
                            end
                        end
                    end
                    OP_ST, OP_LD: begin
                        if (step == 2'd0) begin
                            o_ctrlRegBusSel = rs; o_ctrlRegBusEn = 1'b1; o_ctrlRamAddressEn = 1'b1;
                        end else if (op == OP_ST) begin
                            o_ctrlRegBusSel = rd; o_ctrlRegBusEn = 1'b1; o_ctrlRamWriteEn = 1'b1;
                        end else begin
                            o_ctrlRamOE = 1'b1;
                            {o_ctrlRegWr1, o_ctrlRegWr0} = rd ? 2'b10 : 2'b01;
                        end
                    end
                    OP_JZ: begin
                        if (!jz_take) begin
                            o_ctrlPcInc = 1'b1;    // skip the target byte
                        end else if (step == 2'd0) begin
                            o_ctrlPcOE = 1'b1;  o_ctrlRamAddressEn = 1'b1;
                        end else begin
                            o_ctrlRamOE = 1'b1; o_ctrlPcLoad = 1'b1;
                        end
                    end
                    default: ;  // NOP and HLT issue no strobes
                endcase
            end
            S_HALT:  o_halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench for control_sequencer: a per-instruction
// reference model expands each opcode into its expected strobe vectors.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] bus = 8'h00;
    logic       fz  = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    logic       step_req = 1'b1;
`endif

    logic pcoe, pcinc, pcld, pcclr, rae, ramoe, ramwe, sel, regen, wr0, wr1, alub, shl, aluoe, halted;
    logic [1:0] aluop;

    control_sequencer dut (
        .i_clk(clk), .i_reset(rst),
`ifdef SEQ_SINGLE_STEP_EN
        .i_stepReq(step_req),
`endif
        .i_bus(bus), .i_flagZero(fz),
        .o_ctrlPcOE(pcoe), .o_ctrlPcInc(pcinc), .o_ctrlPcLoad(pcld), .o_ctrlPcClear(pcclr),
        .o_ctrlRamAddressEn(rae), .o_ctrlRamOE(ramoe), .o_ctrlRamWriteEn(ramwe),
        .o_ctrlRegBusSel(sel), .o_ctrlRegBusEn(regen), .o_ctrlRegWr0(wr0), .o_ctrlRegWr1(wr1),
        .o_ctrlAluBWr(alub), .o_ctrlAluOp(aluop), .o_ctrlAluShiftLeft(shl),
        .o_ctrlAluOE(aluoe), .o_halted(halted)
    );

    always #5 clk = ~clk;

    typedef logic [16:0] vec_t;
    localparam int PCOE = 0, PCINC = 1, PCLD = 2, PCCLR = 3, RAE = 4, RAMOE = 5, RAMWE = 6,
                   SEL = 7, REGEN = 8, WR0 = 9, WR1 = 10, ALUB = 11, OP0 = 12, SHL = 14,
                   ALUOE = 15, HALT = 16;

    vec_t act;
    assign act = {halted, aluoe, shl, aluop, alub, wr1, wr0, regen, sel, ramwe, ramoe, rae,
                  pcclr, pcld, pcinc, pcoe};

    vec_t exp_q[$];
    vec_t seq[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t b(int i);
        return vec_t'(1) << i;
    endfunction
    function automatic vec_t wr(logic r);
        return r ? b(WR1) : b(WR0);
    endfunction
    function automatic vec_t rsel(logic r);
        return r ? b(SEL) : vec_t'(0);
    endfunction

    // Reference model: full cycle-by-cycle strobe list for one instruction
    function automatic void build(logic [7:0] ir, logic z);
        logic  rd, rs;
        vec_t  aop, sop;
        rd  = ir[4];
        rs  = ir[3];
        aop = vec_t'(ir[1:0]) << OP0;
        sop = (vec_t'(3) << OP0) | (ir[2] ? b(SHL) : vec_t'(0)) | rsel(rd);
        seq.delete();
        seq.push_back(b(PCOE) | b(RAE));
        seq.push_back(b(RAMOE) | b(PCINC));
        case (ir[7:5])
            3'd0: seq.push_back('0);
            3'd1: begin
                seq.push_back(b(PCOE) | b(RAE));
                seq.push_back(b(RAMOE) | b(PCINC) | wr(rd));
            end
            3'd2: begin
                seq.push_back(rsel(rs) | b(REGEN) | b(ALUB));
                seq.push_back(aop);
                seq.push_back(aop | b(ALUOE) | wr(rd));
            end
            3'd3: begin
                seq.push_back(b(PCOE) | b(RAE));
                seq.push_back(b(RAMOE) | b(PCINC) | b(ALUB));
                seq.push_back(sop);
                seq.push_back(sop | b(ALUOE) | wr(rd));
            end
            3'd4: begin
                seq.push_back(rsel(rs) | b(REGEN) | b(RAE));
                seq.push_back(rsel(rd) | b(REGEN) | b(RAMWE));
            end
            3'd5: begin
                seq.push_back(rsel(rs) | b(REGEN) | b(RAE));
                seq.push_back(b(RAMOE) | wr(rd));
            end
            3'd6: begin
                if (z) begin
                    seq.push_back(b(PCOE) | b(RAE));
                    seq.push_back(b(RAMOE) | b(PCLD));
                end else begin
                    seq.push_back(b(PCINC));
                end
            end
            default: seq.push_back('0);
        endcase
    endfunction

    task automatic cycle(input vec_t e);
        @(posedge clk); #1;
        exp_q.push_back(e);
    endtask

    // Run the first n cycles of one instruction (n<0: all of it)
    task automatic run(input logic [7:0] ir, input logic z, input int n);
        int lim;
        build(ir, z);
        bus = ir;
        fz  = z;
        lim = (n < 0) ? seq.size() : n;
        for (int i = 0; i < lim; i++) cycle(seq[i]);
    endtask

    task automatic rand_instrs(input int n);
        logic [7:0] ir;
        for (int k = 0; k < n; k++) begin
            ir      = 8'($urandom);
            ir[7:5] = 3'($urandom_range(0, 6));
            run(ir, 1'($urandom_range(0, 1)), -1);
        end
    endtask

    // Monitor: pops one expected vector per cycle and checks bus exclusivity
    always @(negedge clk) begin
        vec_t e;
        int   drv;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL strobes t=%0t got=%05h want=%05h", $time, act, e);
            end
            drv = int'(pcoe) + int'(ramoe) + int'(regen) + int'(aluoe);
            total++;
            if (drv > 1) begin
                bad++;
                $display("FAIL bus_drivers t=%0t got=%0d want<=1", $time, drv);
            end
        end
    end

    initial begin
        // reset held 10 cycles, then released; the release cycle is still RESET
        for (int i = 0; i < 10; i++) cycle(b(PCCLR));
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back(b(PCCLR));

        // directed cases
        run(8'h20, 1'b0, -1);   // LDI r0
        run(8'h48, 1'b0, -1);   // ALU r0 = r0 op r1
        run(8'h88, 1'b1, -1);   // ST [r1] = r0
        run(8'h10, 1'b1, -1);   // NOP-class byte; rd bit set
        run(8'hC0, 1'b1, -1);   // JZ taken
        run(8'hC0, 1'b0, -1);   // JZ not taken
        run(8'h7C, 1'b0, -1);   // SHIFT r1 left
        run(8'hB8, 1'b0, -1);   // LD r1 <- [r1]

        rand_instrs(60);

        // reset in ALU step 1: strobes must drop immediately
        run(8'h5B, 1'b0, 4);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        total++;
        if (act !== b(PCCLR)) begin
            bad++;
            $display("FAIL async_reset got=%05h want=%05h", act, b(PCCLR));
        end
        cycle(b(PCCLR));
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back(b(PCCLR));

        rand_instrs(30);

        // HLT then terminal HALT
        run(8'hE0, 1'b0, -1);
        for (int i = 0; i < 6; i++) cycle(b(HALT));

        repeat (3) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
